des_key_sequencer_dec: RTL and testbench
========================================

Name: des_key_sequencer_dec

Overview:
- Iterative DES decryption key scheduler: after one PC1 load, emits the 16 round subkeys in reverse order, K16 first and K1 last, one per handshake.
- Feeds a round-serial DES decrypt datapath.
- Counterpart to the combinational all-16-subkeys encryption schedule. It replaces the 16 parallel PC2 instances with one rotating C/D register pair and a single PC2.
- PC1 and PC2 are reused unchanged from the existing permutation modules.

Parameters:
- none (DES widths are fixed: key 64, C/D 28+28, subkey 48)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a schedule; sampled only in IDLE
- key  in  64  DES key incl. parity bits; sampled in the cycle start is accepted
- subkey_ready  in  1  consumer accepts the current subkey
- subkey_valid  out  1  subkey/round_idx are valid
- subkey  out  48  PC2 of the current C/D registers
- round_idx  out  4  0..15; emission order, so the subkey emitted is K(16-round_idx)
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse after the 16th handshake

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; C/D regs=0; round_idx=0.
  - subkey_valid=0, busy=0, done=0.
  - subkey output follows PC2(0)=0.
- Shift table s[n], n=1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (total 28, so C16D16 == C0D0).
- States: IDLE, EMIT, FIN.
- IDLE:
  - start=1 at edge t: {C,D} <= PC1(key), round_idx <= 0, state -> EMIT.
  - At t+1: busy=1 and subkey_valid=1, with subkey = PC2(C0D0) = K16.
- EMIT:
  - subkey_valid=1 throughout.
  - Handshake is subkey_valid & subkey_ready at a rising edge.
  - On handshake at round_idx=i<15: C <= ROR(C, s[16-i]), D <= ROR(D, s[16-i]) (28-bit rotate-right of each half independently); round_idx <= i+1.
  - On handshake at round_idx=15 (K1): state -> FIN; subkey_valid <= 0.
  - Without a handshake, C/D/round_idx hold. subkey must be stable while valid & !ready.
- FIN:
  - done=1 for exactly one cycle; busy=0 in that cycle.
  - Next cycle: state -> IDLE, round_idx <= 0.
  - C/D are not cleared; subkey output is don't-care while subkey_valid=0.
- Boundary and overlap rules:
  - start while in EMIT or FIN is ignored; key is not re-sampled.
  - start in the cycle after done (IDLE) is accepted normally. Back-to-back schedules therefore have exactly one idle cycle between the 16th handshake's FIN and the next K16.
  - subkey_ready tied high: 16 subkeys on 16 consecutive cycles, t+1..t+16; done at t+17.
  - subkey_ready low in IDLE/FIN: no effect.
  - rst_n asserted mid-schedule: immediate return to reset values, no done pulse. After release, start is required again.
- The implementation has no combinational path from subkey_ready or start to any output.

Optional Feature:
- DES_KS_BIDIR_EN: adds input port `encrypt` (1 bit), sampled with key on start acceptance and held internally for the schedule.
  - encrypt=1: load {C,D} <= ROL1 of each half of PC1(key), so the first subkey is K1. Each handshake at round_idx=i<15 rotates left by s[i+2]; order emitted is K1..K16.
  - encrypt=0: decryption behaviour exactly as above.
  - Macro undefined: no encrypt port; decryption order only.
  - Handshake, timing and done rules are identical in both modes.

Test Plan:
- Key 0x133457799BBCDFF1, start, ready=1 -> round_idx 0 gives subkey 0xCB3D8B0E17F5 (K16); round_idx 15 gives 0x1B02EFFC7072 (K1). All 16 values match the standard DES vectors in reverse; done at t+17.
- Weak key 0x0101010101010101 -> all 16 subkeys 0x000000000000. Weak key 0xFEFEFEFEFEFEFEFE -> all 16 subkeys 0xFFFFFFFFFFFF. Parity-bit-only changes to the key give identical subkeys.
- Key 0x133457799BBCDFF1 with random ready stalls (ready low 0-5 cycles) -> subkey/round_idx hold stable while valid&!ready. Sequence identical to the ready=1 run; exactly 16 transfers.
- start pulsed in EMIT with different key 0xFFFF... -> ignored; current sequence is unchanged. start in the cycle after done -> new K16 appears the next cycle.
- rst_n low at round_idx=7 -> valid/busy/done drop immediately, round_idx=0, no done. Restart yields the full correct sequence.
- With DES_KS_BIDIR_EN, key 0x133457799BBCDFF1, encrypt=1 -> first subkey 0x1B02EFFC7072, last 0xCB3D8B0E17F5. encrypt=0 reproduces the first scenario.

Source files
------------

// File: rtl/des_key_sequencer_dec.sv
// des_key_sequencer_dec: iterative DES key schedule for a round-serial decrypt core.
// One PC1 load, then one rotating C/D register pair feeding a single PC2,
// emitting K16..K1 (one subkey per valid/ready handshake).
// Optional build macro DES_KS_BIDIR_EN adds an `encrypt` input that selects
// K1..K16 order (left rotations) instead of the default decryption order.
module des_key_sequencer_dec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
`ifdef DES_KS_BIDIR_EN
    input  logic        encrypt,
`endif
    input  logic        subkey_ready,
    output logic        subkey_valid,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    // DES bit numbering: position 1 is the MSB of the source vector.
    localparam logic [0:55][5:0] PC1_TAB = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [0:47][5:0] PC2_TAB = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  pos;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            pos       = 6'(7'd64 - 7'(PC1_TAB[i]));
            r[55 - i] = k[pos];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  pos;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            pos       = 6'(7'd56 - 7'(PC2_TAB[i]));
            r[47 - i] = cd[pos];
        end
        return r;
    endfunction

    // Per-round shift s[n], n = 1..16; the table sums to 28 so C16D16 == C0D0.
    function automatic logic [1:0] shift_amt(input logic [4:0] n);
        if (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    state_t      state, state_nxt;
    logic [27:0] c_reg, d_reg;
    logic [55:0] pc1_key;
    logic        enc_mode;
    logic        handshake;
    logic        last_round;
    logic [1:0]  rot_dec, rot_enc;

    assign pc1_key    = pc1(key);
    assign handshake  = (state == EMIT) && subkey_ready;
    assign last_round = (round_idx == 4'd15);
    // Decrypt walks C(16-i) -> C(15-i) with ROR by s[16-i]; encrypt walks
    // C(i+1) -> C(i+2) with ROL by s[i+2].
    assign rot_dec    = shift_amt(5'(5'd16 - {1'b0, round_idx}));
    assign rot_enc    = shift_amt(5'({1'b0, round_idx} + 5'd2));
    assign subkey     = pc2({c_reg, d_reg});

`ifdef DES_KS_BIDIR_EN
    logic enc_q;

    // Capture the direction with the key so it stays fixed for the whole schedule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            enc_q <= 1'b0;
        else if (state == IDLE && start)
            enc_q <= encrypt;
    end

    assign enc_mode = enc_q;
`else
    assign enc_mode = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and control outputs; outputs decode state only, never inputs.
    always_comb begin
        state_nxt    = state;
        subkey_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = EMIT;
            end
            EMIT: begin
                subkey_valid = 1'b1;
                busy         = 1'b1;
                if (handshake && last_round)
                    state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // C/D load on start, rotate on each non-final handshake, round counter tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg     <= '0;
            d_reg     <= '0;
            round_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef DES_KS_BIDIR_EN
                        if (encrypt) begin
                            c_reg <= rol28(pc1_key[55:28], 2'd1);
                            d_reg <= rol28(pc1_key[27:0], 2'd1);
                        end else begin
                            c_reg <= pc1_key[55:28];
                            d_reg <= pc1_key[27:0];
                        end
`else
                        c_reg <= pc1_key[55:28];
                        d_reg <= pc1_key[27:0];
`endif
                        round_idx <= '0;
                    end
                end
                EMIT: begin
                    if (handshake && !last_round) begin
                        if (enc_mode) begin
                            c_reg <= rol28(c_reg, rot_enc);
                            d_reg <= rol28(d_reg, rot_enc);
                        end else begin
                            c_reg <= ror28(c_reg, rot_dec);
                            d_reg <= ror28(d_reg, rot_dec);
                        end
                        round_idx <= round_idx + 4'd1;
                    end
                end
                FIN: begin
                    round_idx <= '0;
                end
                default: begin
                    round_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sequencer_dec.sv
// Scoreboard bench for des_key_sequencer_dec: expected subkeys are queued at
// start and popped on each valid/ready handshake.
`timescale 1ns/1ps
module tb_des_key_sequencer_dec;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] key;
    logic        subkey_ready;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
`ifdef DES_KS_BIDIR_EN
    logic        encrypt;
`endif

    des_key_sequencer_dec dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key          (key),
`ifdef DES_KS_BIDIR_EN
        .encrypt      (encrypt),
`endif
        .subkey_ready (subkey_ready),
        .subkey_valid (subkey_valid),
        .subkey       (subkey),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  idx;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] kstd [16];   // kstd[n-1] = Kn for key 133457799BBCDFF1
    int          n_cmp;
    int          n_bad;

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_std(input bit enc_order);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.sk  = enc_order ? kstd[i] : kstd[15 - i];
            e.idx = 4'(i);
            sb.push_back(e);
        end
    endtask

    task automatic push_const(input logic [47:0] v);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.sk  = v;
            e.idx = 4'(i);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input logic [63:0] k, input bit enc);
        start = 1'b1;
        key   = k;
`ifdef DES_KS_BIDIR_EN
        encrypt = enc;
`else
        if (enc) $display("note: encrypt requested without DES_KS_BIDIR_EN");
`endif
        step();
        start = 1'b0;
        key   = 64'hDEADBEEFCAFEF00D;
`ifdef DES_KS_BIDIR_EN
        encrypt = ~enc;
`endif
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        subkey_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl valid=%b busy=%b done=%b required 0/0/0", subkey_valid, busy, done);
        end
        n_cmp++;
        if (round_idx !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_round_idx got %0d required 0", round_idx);
        end
        n_cmp++;
        if (subkey !== 48'h0) begin
            n_bad++;
            $display("FAIL reset_subkey got %h required 000000000000", subkey);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        n_cmp++;
        if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ready_no_effect valid=%b busy=%b done=%b required 0/0/0", subkey_valid, busy, done);
        end
    endtask

    task automatic test_standard();
        exp_t e;
        push_std(1'b0);
        subkey_ready = 1'b1;
        do_start(KEY_STD, 1'b0);
        for (int c = 0; c < 16; c++) begin
            n_cmp++;
            if (subkey_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL std_ctrl cyc=%0d valid=%b busy=%b done=%b required 1/1/0", c, subkey_valid, busy, done);
            end
            e = sb.pop_front();
            n_cmp++;
            if (subkey !== e.sk || round_idx !== e.idx) begin
                n_bad++;
                $display("FAIL std_subkey cyc=%0d got %h idx %0d required %h idx %0d", c, subkey, round_idx, e.sk, e.idx);
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || subkey_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL std_done done=%b busy=%b valid=%b required 1/0/0", done, busy, subkey_valid);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || subkey_valid !== 1'b0 || round_idx !== 4'd0) begin
            n_bad++;
            $display("FAIL std_done_pulse done=%b valid=%b idx=%0d required 0/0/0", done, subkey_valid, round_idx);
        end
    endtask

    task automatic test_weak_and_parity();
        logic [63:0] keys [3];
        exp_t        e;
        keys[0] = 64'h0101010101010101;
        keys[1] = 64'hFEFEFEFEFEFEFEFE;
        keys[2] = KEY_STD ^ 64'h0101010101010101;
        subkey_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      push_const(48'h000000000000);
            else if (k == 1) push_const(48'hFFFFFFFFFFFF);
            else             push_std(1'b0);
            do_start(keys[k], 1'b0);
            for (int c = 0; c < 16; c++) begin
                e = sb.pop_front();
                n_cmp++;
                if (subkey_valid !== 1'b1 || subkey !== e.sk || round_idx !== e.idx) begin
                    n_bad++;
                    $display("FAIL weak_parity key=%h cyc=%0d valid=%b got %h idx %0d required %h idx %0d",
                             keys[k], c, subkey_valid, subkey, round_idx, e.sk, e.idx);
                end
                step();
            end
            n_cmp++;
            if (done !== 1'b1) begin
                n_bad++;
                $display("FAIL weak_parity_done key=%h done=%b required 1", keys[k], done);
            end
            step();
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   stall;
        int   xfers;
        int   cycles;
        push_std(1'b0);
        subkey_ready = 1'b0;
        do_start(KEY_STD, 1'b0);
        stall  = int'($urandom_range(0, 5));
        xfers  = 0;
        cycles = 0;
        while (xfers < 16 && cycles < 300) begin
            if (stall > 0) begin
                subkey_ready = 1'b0;
                stall--;
            end else begin
                subkey_ready = 1'b1;
            end
            n_cmp++;
            if (subkey_valid !== 1'b1 || sb.size() == 0) begin
                n_bad++;
                $display("FAIL stall_valid cyc=%0d valid=%b pending=%0d required 1 with pending", cycles, subkey_valid, sb.size());
            end else begin
                e = sb[0];
                n_cmp++;
                if (subkey !== e.sk || round_idx !== e.idx) begin
                    n_bad++;
                    $display("FAIL stall_hold cyc=%0d ready=%b got %h idx %0d required %h idx %0d",
                             cycles, subkey_ready, subkey, round_idx, e.sk, e.idx);
                end
            end
            if (subkey_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                xfers++;
                stall = int'($urandom_range(0, 5));
            end
            step();
            cycles++;
        end
        subkey_ready = 1'b0;
        n_cmp++;
        if (xfers != 16 || done !== 1'b1 || subkey_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_end xfers=%0d done=%b valid=%b required 16/1/0", xfers, done, subkey_valid);
        end
        step();
        n_cmp++;
        if (subkey_valid !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_extra valid=%b done=%b required 0/0", subkey_valid, done);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        push_std(1'b0);
        subkey_ready = 1'b1;
        do_start(KEY_STD, 1'b0);
        for (int c = 0; c < 16; c++) begin
            start = (c == 3) || (c == 4);
            key   = 64'hFFFFFFFFFFFFFFFF;
            e = sb.pop_front();
            n_cmp++;
            if (subkey_valid !== 1'b1 || subkey !== e.sk || round_idx !== e.idx) begin
                n_bad++;
                $display("FAIL emit_start_ignored cyc=%0d valid=%b got %h idx %0d required %h idx %0d",
                         c, subkey_valid, subkey, round_idx, e.sk, e.idx);
            end
            step();
        end
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_done done=%b required 1", done);
        end
        // start during FIN must be dropped
        start = 1'b1;
        key   = 64'hFFFFFFFFFFFFFFFF;
        step();
        start = 1'b0;
        n_cmp++;
        if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL fin_start_ignored valid=%b busy=%b done=%b required 0/0/0", subkey_valid, busy, done);
        end
        push_const(48'h000000000000);
        do_start(64'h0101010101010101, 1'b0);
        for (int c = 0; c < 16; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (subkey_valid !== 1'b1 || subkey !== e.sk || round_idx !== e.idx) begin
                n_bad++;
                $display("FAIL b2b_second cyc=%0d valid=%b got %h idx %0d required %h idx %0d",
                         c, subkey_valid, subkey, round_idx, e.sk, e.idx);
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second_done done=%b required 1", done);
        end
        step();
    endtask

    task automatic test_mid_reset();
        exp_t e;
        push_std(1'b0);
        subkey_ready = 1'b1;
        do_start(KEY_STD, 1'b0);
        for (int c = 0; c < 7; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (subkey !== e.sk || round_idx !== e.idx) begin
                n_bad++;
                $display("FAIL pre_reset cyc=%0d got %h idx %0d required %h idx %0d", c, subkey, round_idx, e.sk, e.idx);
            end
            step();
        end
        n_cmp++;
        if (round_idx !== 4'd7 || subkey_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_idx idx=%0d valid=%b required 7/1", round_idx, subkey_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_idx !== 4'd0 || subkey !== 48'h0) begin
            n_bad++;
            $display("FAIL async_reset valid=%b busy=%b done=%b idx=%0d subkey=%h required 0/0/0/0/0",
                     subkey_valid, busy, done, round_idx, subkey);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++;
            if (subkey_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset_idle cyc=%0d valid=%b done=%b busy=%b required 0/0/0", c, subkey_valid, done, busy);
            end
        end
        push_std(1'b0);
        do_start(KEY_STD, 1'b0);
        for (int c = 0; c < 16; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (subkey_valid !== 1'b1 || subkey !== e.sk || round_idx !== e.idx) begin
                n_bad++;
                $display("FAIL restart cyc=%0d valid=%b got %h idx %0d required %h idx %0d",
                         c, subkey_valid, subkey, round_idx, e.sk, e.idx);
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_done done=%b required 1", done);
        end
        step();
    endtask

`ifdef DES_KS_BIDIR_EN
    task automatic test_encrypt();
        exp_t e;
        push_std(1'b1);
        subkey_ready = 1'b1;
        do_start(KEY_STD, 1'b1);
        for (int c = 0; c < 16; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (subkey_valid !== 1'b1 || subkey !== e.sk || round_idx !== e.idx) begin
                n_bad++;
                $display("FAIL encrypt cyc=%0d valid=%b got %h idx %0d required %h idx %0d",
                         c, subkey_valid, subkey, round_idx, e.sk, e.idx);
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL encrypt_done done=%b required 1", done);
        end
        step();
        encrypt = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        kstd[0]  = 48'h1B02EFFC7072;
        kstd[1]  = 48'h79AED9DBC9E5;
        kstd[2]  = 48'h55FC8A42CF99;
        kstd[3]  = 48'h72ADD6DB351D;
        kstd[4]  = 48'h7CEC07EB53A8;
        kstd[5]  = 48'h63A53E507B2F;
        kstd[6]  = 48'hEC84B7F618BC;
        kstd[7]  = 48'hF78A3AC13BFB;
        kstd[8]  = 48'hE0DBEBEDE781;
        kstd[9]  = 48'hB1F347BA464F;
        kstd[10] = 48'h215FD3DED386;
        kstd[11] = 48'h7571F59467E9;
        kstd[12] = 48'h97C5D1FABA41;
        kstd[13] = 48'h5F43B7F2E73A;
        kstd[14] = 48'hBF918D3D3F0A;
        kstd[15] = 48'hCB3D8B0E17F5;
        rst_n        = 1'b0;
        start        = 1'b0;
        key          = '0;
        subkey_ready = 1'b0;
`ifdef DES_KS_BIDIR_EN
        encrypt      = 1'b0;
`endif
        test_reset();
        test_standard();
        test_weak_and_parity();
        test_stall();
        test_back_to_back();
        test_mid_reset();
`ifdef DES_KS_BIDIR_EN
        test_encrypt();
        test_standard();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
